bit_n_divider: RTL and testbench

BIT_N_DIVIDER -- requirements
Module: bit_n_divider

---
 rtl/bit_n_divider.sv | 120 ++++++++++++
 tb/tb_bit_n_divider.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_n_divider.sv
// Programmable N-cycle divider with free-run and one-shot modes, a square-wave
// output and a scan-select index that advances once per wrap.
module bit_n_divider #(
  parameter int               WIDTH     = 10,
  parameter int               DIGITS    = 4,
  parameter int               SEL_W     = 2,
  parameter logic [WIDTH-1:0] RESET_DIV = {WIDTH{1'b1}}
) (
  input  logic             clk_div,
  input  logic             rst_div,
  input  logic             en_div,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  input  logic             mode_div,
  input  logic             start_div,
  output logic [WIDTH-1:0] count_div,
  output logic             tick_div,
  output logic             sq_div,
  output logic             msb_div,
  output logic [SEL_W-1:0] sel_div,
  output logic             busy_div
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q,  term_d;
  logic             tick_q,  tick_d;
  logic             sq_q,    sq_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [SEL_W-1:0] sel_inc;

  // Scan index wraps at DIGITS-1 rather than at the natural power of two.
  always_comb begin
    if (sel_q == SEL_LAST) begin
      sel_inc = '0;
    end else begin
      sel_inc = sel_q + SEL_W'(1);
    end
  end

  // Next-state logic; a load always takes priority over counting.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    tick_d  = 1'b0;
    sq_d    = sq_q;
    sel_d   = sel_q;
    if (div_load) begin
      term_d  = div_val;
      count_d = '0;
    end else if (en_div) begin
      case (state_q)
        ST_IDLE: begin
          count_d = '0;
          if (!mode_div || start_div) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (count_q == term_q) begin
            count_d = '0;
            tick_d  = 1'b1;
            sq_d    = ~sq_q;
            sel_d   = sel_inc;
            if (mode_div) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end else begin
      tick_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_div) begin
    if (rst_div) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      term_q  <= RESET_DIV;
      tick_q  <= 1'b0;
      sq_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      tick_q  <= tick_d;
      sq_q    <= sq_d;
      sel_q   <= sel_d;
    end
  end

  assign count_div = count_q;
  assign tick_div  = tick_q;
  assign sq_div    = sq_q;
  assign sel_div   = sel_q;
  assign msb_div   = count_q[WIDTH-1];
  assign busy_div  = (state_q == ST_RUN);

endmodule

// File: tb/tb_bit_n_divider.sv
// Scoreboard bench for bit_n_divider: a cycle model pushes expected outputs,
// each cycle pops and compares; scenario tasks add directed checks.
module tb_bit_n_divider;
  localparam int W = 10;
  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, ld, mode, start;
  logic [W-1:0] val;
  logic [W-1:0] count_s;
  logic         tick_s, sq_s, msb_s, busy_s;
  logic [S-1:0] sel_s;

  bit_n_divider #(.WIDTH(W), .DIGITS(D), .SEL_W(S)) dut (
    .clk_div(clk), .rst_div(rst), .en_div(en), .div_load(ld), .div_val(val),
    .mode_div(mode), .start_div(start), .count_div(count_s), .tick_div(tick_s),
    .sq_div(sq_s), .msb_div(msb_s), .sel_div(sel_s), .busy_div(busy_s)
  );

  typedef struct packed {
    logic [W-1:0] count;
    logic         tick;
    logic         sq;
    logic         msb;
    logic [S-1:0] sel;
    logic         busy;
  } obs_t;

  obs_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   n_tick = 0;
  int   n_busy = 0;

  logic [W-1:0] m_count, m_term;
  logic         m_run, m_tick, m_sq;
  logic [S-1:0] m_sel;

  task automatic model_step();
    if (rst) begin
      m_count = '0; m_term = {W{1'b1}}; m_run = 1'b0; m_tick = 1'b0; m_sq = 1'b0; m_sel = '0;
    end else if (ld) begin
      m_term = val; m_count = '0; m_tick = 1'b0;
    end else if (!en) begin
      m_tick = 1'b0;
    end else if (!m_run) begin
      m_tick = 1'b0; m_count = '0;
      if (!mode || start) m_run = 1'b1;
    end else if (m_count == m_term) begin
      m_count = '0; m_tick = 1'b1; m_sq = ~m_sq;
      m_sel = S'((int'(m_sel) + 1) % D);
      if (mode) m_run = 1'b0;
    end else begin
      m_count = m_count + 10'd1; m_tick = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic l, input logic [W-1:0] v,
                      input logic m, input logic s);
    obs_t exp_v, act_v;
    @(negedge clk);
    rst = r; en = e; ld = l; val = v; mode = m; start = s;
    model_step();
    exp_v = {m_count, m_tick, m_sq, m_count[W-1], m_sel, m_run};
    exp_q.push_back(exp_v);
    @(posedge clk); #1;
    act_v = {count_s, tick_s, sq_s, msb_s, sel_s, busy_s};
    if (tick_s) n_tick++;
    if (busy_s) n_busy++;
    exp_v = exp_q.pop_front();
    total++;
    if (act_v !== exp_v) $display("FAIL scoreboard t=%0t actual=%h required=%h", $time, act_v, exp_v);
    else passed++;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    total++;
    if ({count_s, tick_s, sq_s, msb_s, sel_s, busy_s} !== 16'h0000)
      $display("FAIL reset_state actual=%h required=0", {count_s, tick_s, sq_s, msb_s, sel_s, busy_s});
    else passed++;
  endtask

  task automatic test_free_run();
    int first_tick, last_tick, ticks, msb_hi, gap_bad, k;
    logic [S-1:0] sel_exp [5];
    logic [S-1:0] sel_seen[5];
    sel_exp[0] = 2'd1; sel_exp[1] = 2'd2; sel_exp[2] = 2'd3; sel_exp[3] = 2'd0; sel_exp[4] = 2'd1;
    first_tick = -1; last_tick = 0; ticks = 0; msb_hi = 0; gap_bad = 0; k = 0;
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 5121; i++) begin
      step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
      if (i <= 1024 && msb_s) msb_hi++;
      if (tick_s) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
        else if (i - last_tick != 1024) gap_bad++;
        last_tick = i;
        if (k < 5) begin sel_seen[k] = sel_s; k++; end
      end
    end
    total++; if (first_tick !== 1025) $display("FAIL first_tick actual=%0d required=1025", first_tick); else passed++;
    total++; if (ticks !== 5) $display("FAIL tick_count actual=%0d required=5", ticks); else passed++;
    total++; if (gap_bad !== 0) $display("FAIL tick_period bad_gaps=%0d required=0", gap_bad); else passed++;
    total++; if (msb_hi !== 512) $display("FAIL msb_duty actual=%0d required=512", msb_hi); else passed++;
    for (int j = 0; j < 5; j++) begin
      total++;
      if (sel_seen[j] !== sel_exp[j]) $display("FAIL sel_seq[%0d] actual=%0d required=%0d", j, sel_seen[j], sel_exp[j]);
      else passed++;
    end
  endtask

  task automatic test_load4();
    int ticks, last_tick, gap_bad, max_cnt, last_rise, sq_bad;
    logic sq_prev;
    ticks = 0; last_tick = 0; gap_bad = 0; max_cnt = 0; last_rise = 0; sq_bad = 0;
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 10'd4, 1'b0, 1'b0);
    total++; if (busy_s !== 1'b0) $display("FAIL load_keeps_idle actual=%0b required=0", busy_s); else passed++;
    sq_prev = sq_s;
    for (int i = 1; i <= 31; i++) begin
      step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
      if (int'(count_s) > max_cnt) max_cnt = int'(count_s);
      if (tick_s) begin
        if (ticks > 0 && i - last_tick != 5) gap_bad++;
        ticks++; last_tick = i;
      end
      if (sq_s && !sq_prev) begin
        if (last_rise > 0 && i - last_rise != 10) sq_bad++;
        last_rise = i;
      end
      sq_prev = sq_s;
    end
    total++; if (ticks !== 6) $display("FAIL load4_ticks actual=%0d required=6", ticks); else passed++;
    total++; if (gap_bad !== 0) $display("FAIL load4_period bad_gaps=%0d required=0", gap_bad); else passed++;
    total++; if (sq_bad !== 0) $display("FAIL load4_sq_period bad=%0d required=0", sq_bad); else passed++;
    total++; if (max_cnt !== 4) $display("FAIL load4_max_count actual=%0d required=4", max_cnt); else passed++;
  endtask

  task automatic test_one_shot();
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 10'd3, 1'b1, 1'b0);
    n_tick = 0; n_busy = 0;
    for (int i = 1; i <= 14; i++)
      step(1'b0, 1'b1, 1'b0, 10'd0, 1'b1, (i == 1 || i == 3));
    total++; if (n_busy !== 4) $display("FAIL oneshot_busy actual=%0d required=4", n_busy); else passed++;
    total++; if (n_tick !== 1) $display("FAIL oneshot_ticks actual=%0d required=1", n_tick); else passed++;
    total++; if (busy_s !== 1'b0) $display("FAIL oneshot_idle actual=%0b required=0", busy_s); else passed++;
  endtask

  task automatic test_enable_hold();
    int hold_bad;
    hold_bad = 0;
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 10'd9, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    total++; if (count_s !== 10'd2) $display("FAIL hold_setup actual=%0d required=2", count_s); else passed++;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
      if (count_s !== 10'd2 || tick_s !== 1'b0) hold_bad++;
    end
    total++; if (hold_bad !== 0) $display("FAIL hold_count bad_cycles=%0d required=0", hold_bad); else passed++;
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    total++; if (count_s !== 10'd3) $display("FAIL hold_resume actual=%0d required=3", count_s); else passed++;
  endtask

  task automatic test_load_at_wrap();
    logic sq0, sq_prev;
    logic [S-1:0] sel0;
    int bad;
    bad = 0;
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 10'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    sq0 = sq_s; sel0 = sel_s;
    step(1'b0, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0);
    total++; if (tick_s !== 1'b0) $display("FAIL wrap_load_tick actual=%0b required=0", tick_s); else passed++;
    total++; if ({sq_s, sel_s, busy_s} !== {sq0, sel0, 1'b1})
      $display("FAIL wrap_load_state actual=%b required=%b", {sq_s, sel_s, busy_s}, {sq0, sel0, 1'b1});
    else passed++;
    sq_prev = sq_s;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
      if (tick_s !== 1'b1 || sq_s === sq_prev || count_s !== 10'd0) bad++;
      sq_prev = sq_s;
    end
    total++; if (bad !== 0) $display("FAIL term0_every_cycle bad_cycles=%0d required=0", bad); else passed++;
  endtask

  task automatic test_reset_mid();
    int first_tick;
    first_tick = -1;
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 10'd9, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 10'd1023, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    total++; if ({count_s, sel_s} !== {10'd500, 2'd2})
      $display("FAIL mid_setup actual=%0d/%0d required=500/2", count_s, sel_s);
    else passed++;
    step(1'b1, 1'b1, 1'b1, 10'd5, 1'b0, 1'b1);
    total++; if ({count_s, tick_s, sq_s, msb_s, sel_s, busy_s} !== 16'h0000)
      $display("FAIL mid_reset actual=%h required=0", {count_s, tick_s, sq_s, msb_s, sel_s, busy_s});
    else passed++;
    for (int i = 1; i <= 1025; i++) begin
      step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
      if (tick_s && first_tick < 0) first_tick = i;
    end
    total++; if (first_tick !== 1025) $display("FAIL mid_reset_term actual=%0d required=1025", first_tick); else passed++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; val = '0; mode = 1'b0; start = 1'b0;
    test_reset();
    test_free_run();
    test_load4();
    test_one_shot();
    test_enable_hold();
    test_load_at_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
